// File: rtl/ofm_write_addr_gen_if.sv
// Handshake and configuration bundle between the output drain logic and the
// OFM write-address generator. The slave modport is the generator's view.
interface ofm_write_addr_gen_if #(
  parameter int OFM_RAM_SIZE = 259584,
  parameter int MAX_DIM      = 416,
  parameter int MAX_CH_GROUP = 16,
  parameter int MAX_FILTERS  = 1024
);
  localparam int AW = $clog2(OFM_RAM_SIZE);
  localparam int DW = $clog2(MAX_DIM + 1);
  localparam int GW = $clog2(MAX_CH_GROUP + 1);
  localparam int FW = $clog2(MAX_FILTERS + 1);

  logic          start;
  logic [AW-1:0] start_write_addr;
  logic [DW-1:0] ofm_width;
  logic [DW-1:0] ofm_height;
  logic [FW-1:0] num_filters;
  logic [GW-1:0] ch_group_size;
  logic          upsample_mode;
  logic          write;
  logic          addr_ready;
  logic          addr_valid;
  logic [AW-1:0] ofm_addr;
  logic [4:0]    write_ofm_size;
  logic [GW-1:0] ch_idx;
  logic          busy;
  logic          layer_done;
  logic          err_write_busy;

  modport slave (
    input  start, start_write_addr, ofm_width, ofm_height, num_filters,
           ch_group_size, upsample_mode, write, addr_ready,
    output addr_valid, ofm_addr, write_ofm_size, ch_idx, busy, layer_done,
           err_write_busy
  );

  modport master (
    output start, start_write_addr, ofm_width, ofm_height, num_filters,
           ch_group_size, upsample_mode, write, addr_ready,
    input  addr_valid, ofm_addr, write_ofm_size, ch_idx, busy, layer_done,
           err_write_busy
  );
endinterface

// File: rtl/ofm_write_addr_gen.sv
// OFM write-address generator: one (address, burst size, channel) tuple per
// output channel for every tile-row, walking filter group / strip / row / channel.
module ofm_write_addr_gen #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int OFM_RAM_SIZE  = 259584,
  parameter int MAX_DIM       = 416,
  parameter int MAX_CH_GROUP  = 16,
  parameter int MAX_FILTERS   = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ofm_write_addr_gen_if.slave  bus
);
  localparam int AW  = $clog2(OFM_RAM_SIZE);
  localparam int DW  = $clog2(MAX_DIM + 1);
  localparam int GW  = $clog2(MAX_CH_GROUP + 1);
  localparam int FW  = $clog2(MAX_FILTERS + 1);
  localparam int DW1 = DW + 1;
  localparam int FW1 = FW + 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_ADVANCE, S_DONE} state_t;

  state_t        state_q;
  logic          valid_q, busy_q, done_q, err_q;
  logic [AW-1:0] addr_q;
  logic [4:0]    size_q;
  logic [GW-1:0] ch_q;

  // Configuration captured at start.
  logic [AW-1:0] base_q, plane_q, row_step_q, strip_step_q;
  logic [DW-1:0] sw_q, sh_q;
  logic [FW-1:0] nf_q;
  logic [GW-1:0] g_q;

  // Loop counters and running address offsets (adders only per cycle).
  logic [DW-1:0] r_q, sc_q;
  logic [FW-1:0] fil_base_q, fil_q;
  logic [AW-1:0] grp_off_q, ch_off_q, strip_off_q, sp_off_q;

  logic [DW-1:0]  remaining;
  logic [4:0]     size_d;
  logic [FW1-1:0] fil_next;
  logic           last_ch, row_wrap, strip_wrap, layer_end, handshake;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    remaining  = sw_q - sc_q;
    size_d     = remaining[4:0];
    if (remaining >= DW'(SYSTOLIC_SIZE)) size_d = 5'(SYSTOLIC_SIZE);
    last_ch    = ((ch_q + GW'(1)) == g_q) || ((FW1'(fil_q) + FW1'(1)) >= FW1'(nf_q));
    row_wrap   = (DW1'(r_q) + DW1'(1)) >= DW1'(sh_q);
    strip_wrap = (DW1'(sc_q) + DW1'(SYSTOLIC_SIZE)) >= DW1'(sw_q);
    fil_next   = FW1'(fil_base_q) + FW1'(g_q);
    layer_end  = fil_next >= FW1'(nf_q);
    handshake  = valid_q && bus.addr_ready;
  end

  // NOTE: clocked state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      ch_q         <= '0;
      base_q       <= '0;
      plane_q      <= '0;
      row_step_q   <= '0;
      strip_step_q <= '0;
      sw_q         <= '0;
      sh_q         <= '0;
      nf_q         <= '0;
      g_q          <= '0;
      r_q          <= '0;
      sc_q         <= '0;
      fil_base_q   <= '0;
      fil_q        <= '0;
      grp_off_q    <= '0;
      ch_off_q     <= '0;
      strip_off_q  <= '0;
      sp_off_q     <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (bus.start) begin
        // start wins over everything, including a simultaneous write
        state_q      <= S_WAIT;
        valid_q      <= 1'b0;
        busy_q       <= 1'b1;
        addr_q       <= '0;
        size_q       <= '0;
        ch_q         <= '0;
        base_q       <= bus.start_write_addr;
        plane_q      <= AW'(bus.ofm_width) * AW'(bus.ofm_height);
        row_step_q   <= bus.upsample_mode ? (AW'(bus.ofm_width) << 1) : AW'(bus.ofm_width);
        strip_step_q <= bus.upsample_mode ? AW'(2 * SYSTOLIC_SIZE) : AW'(SYSTOLIC_SIZE);
        sw_q         <= bus.upsample_mode ? (bus.ofm_width >> 1) : bus.ofm_width;
        sh_q         <= bus.upsample_mode ? (bus.ofm_height >> 1) : bus.ofm_height;
        nf_q         <= bus.num_filters;
        g_q          <= bus.ch_group_size;
        r_q          <= '0;
        sc_q         <= '0;
        fil_base_q   <= '0;
        fil_q        <= '0;
        grp_off_q    <= '0;
        ch_off_q     <= '0;
        strip_off_q  <= '0;
        sp_off_q     <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: ;
          S_WAIT: begin
            if (bus.write) begin
              state_q  <= S_ISSUE;
              valid_q  <= 1'b1;
              addr_q   <= base_q + grp_off_q + sp_off_q;
              ch_off_q <= grp_off_q + plane_q;
              size_q   <= size_d;
              ch_q     <= '0;
              fil_q    <= fil_base_q;
            end
          end
          S_ISSUE: begin
            err_q <= bus.write;
            if (handshake) begin
              if (last_ch) begin
                state_q <= S_ADVANCE;
                valid_q <= 1'b0;
              end else begin
                ch_q     <= ch_q + GW'(1);
                fil_q    <= fil_q + FW'(1);
                addr_q   <= addr_q + plane_q;
                ch_off_q <= ch_off_q + plane_q;
              end
            end
          end
          S_ADVANCE: begin
            err_q   <= bus.write;
            state_q <= S_WAIT;
            if (!row_wrap) begin
              r_q      <= r_q + DW'(1);
              sp_off_q <= sp_off_q + row_step_q;
            end else begin
              r_q <= '0;
              if (!strip_wrap) begin
                sc_q        <= sc_q + DW'(SYSTOLIC_SIZE);
                strip_off_q <= strip_off_q + strip_step_q;
                sp_off_q    <= strip_off_q + strip_step_q;
              end else begin
                sc_q        <= '0;
                strip_off_q <= '0;
                sp_off_q    <= '0;
                fil_base_q  <= fil_next[FW-1:0];
                // after a full group ch_off_q already points at the next group's plane
                grp_off_q   <= ch_off_q;
                if (layer_end) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                end
              end
            end
          end
          S_DONE: begin
            err_q   <= bus.write;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.addr_valid     = valid_q;
  assign bus.ofm_addr       = addr_q;
  assign bus.write_ofm_size = size_q;
  assign bus.ch_idx         = ch_q;
  assign bus.busy           = busy_q;
  assign bus.layer_done     = done_q;
  assign bus.err_write_busy = err_q;
endmodule
